gate_sensor_filter: RTL and testbench
=====================================

Name: gate_sensor_filter

Overview:
Conditioning stage directly upstream of the lot entry/exit detector. Takes the two raw, asynchronous gate photo-sensor lines (a = outer beam, b = inner beam) from GPIO. Produces synchronized, debounced levels plus single-cycle edge strobes, so the direction FSM sees clean a/b transitions only. Also flags a beam held blocked abnormally long (stuck sensor or parked car) for display/LED use.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronized input must differ from its clean level before the clean level flips (10 ms at 50 MHz); legal range 1 and up.
STUCK_CYCLES, 500000000, consecutive cycles a clean level may stay high before its stuck flag sets (10 s at 50 MHz); must be greater than DEBOUNCE_CYCLES.

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst  in  1  reset, asynchronous, active-high
a_raw  in  1  raw outer-beam sensor, asynchronous to clk
b_raw  in  1  raw inner-beam sensor, asynchronous to clk
fault_clr  in  1  synchronous clear of both stuck flags
a_clean  out  1  debounced a level
b_clean  out  1  debounced b level
a_rise  out  1  one-cycle strobe, a_clean 0->1
a_fall  out  1  one-cycle strobe, a_clean 1->0
b_rise  out  1  one-cycle strobe, b_clean 0->1
b_fall  out  1  one-cycle strobe, b_clean 1->0
stuck_fault  out  2  sticky flags, [1]=a, [0]=b

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on rst. While rst is high, every output is 0, sync flops are 0, counters are 0, and each channel state is LO.
- Channels a and b are fully independent. Each uses a 2-flop synchronizer whose output is s, followed by a 4-state FSM.
- LO: clean=0. If s=1, go to PEND_HI with cnt=1; otherwise stay.
- PEND_HI: clean=0. If s=0, return to LO and set cnt=0. If s=1 and cnt==DEBOUNCE_CYCLES-1, go to HI: clean becomes 1 and the rise strobe is 1 on that same edge. Otherwise cnt+1.
- HI: clean=1. If s=0, go to PEND_LO with cnt=1; otherwise stay.
- PEND_LO: mirror of PEND_HI. On completion go to LO: clean becomes 0 and the fall strobe pulses.
- When DEBOUNCE_CYCLES=1, the PEND states are transited in a single cycle; same rule, no special case.
- Latency: a raw level first captured at edge k appears on clean at edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 cycles counting edge k.
- Rejected glitch: any pulse shorter than DEBOUNCE_CYCLES synchronized cycles produces no change on clean and no strobe.
- Strobes: registered, high exactly one cycle. Rise and fall never assert together on one channel.
- Counter width: $clog2(STUCK_CYCLES+1). Counters never wrap; they saturate.
- Stuck detection, per channel, with a separate counter:
  - Counts cycles while clean=1; clears to 0 when clean=0.
  - When it reaches STUCK_CYCLES, the channel's stuck_fault bit sets on that edge and stays set (sticky). The counter holds at STUCK_CYCLES.
- fault_clr=1 clears both stuck_fault bits and both stuck counters on the next edge.
  - If a clean level is still high, counting restarts from 0.
  - If fault_clr coincides with a set condition, clear wins.
- stuck_fault does not alter clean or strobe behaviour.
- Reset mid-debounce or mid-stuck-count discards all progress. After release, a raw level already high re-qualifies with the full DEBOUNCE_CYCLES+2 latency and emits its rise strobe.

Decomposition:
- Package gate_filter_pkg holds:
  - typedef enum logic [1:0] {LO, PEND_HI, HI, PEND_LO} deb_state_t;
  - the stuck_fault index constants A_IDX=1 and B_IDX=0.
- Sub-module debounce_channel contains the synchronizer, FSM, strobes and stuck counter for one channel. It carries both parameters and is instantiated twice.
- gate_sensor_filter itself is wiring plus fault_clr fan-out.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and STUCK_CYCLES=20.
1. a_raw 0->1 just before edge k, then held -> a_clean=1 from edge k+5. a_rise high for exactly that one cycle. b outputs stay 0.
2. b_raw high for 3 cycles then low -> b_clean stays 0. No b_rise or b_fall ever asserts.
3. Entry pattern (a,b) = 10, 11, 01, 00, each held 10 cycles -> clean outputs reproduce the pattern delayed 6 cycles. Exactly one each of a_rise, b_rise, a_fall, b_fall, in that order, 10 cycles apart.
4. a_raw held high for 40 cycles -> stuck_fault=2'b10 exactly 20 cycles after a_clean rises. fault_clr pulse -> 2'b00 next cycle, then 2'b10 again 20 cycles later.
5. rst asserted mid-PEND_HI (cnt=3) with a_raw still 1 -> all outputs 0 immediately, with no clock edge needed. After release, a_clean rises 6 cycles after the first post-reset edge, with one a_rise.
6. a_raw and b_raw switch 0->1 in the same cycle -> a_clean and b_clean rise on the same edge, and a_rise and b_rise pulse together.

Source files
------------

// File: rtl/gate_filter_pkg.sv
// Shared types and constants for the gate sensor conditioning stage.
// Latency: n/a (declarations only).
// Backpressure: n/a; the filter is free-running with no handshake.
package gate_filter_pkg;

  // Per-channel debounce state.
  typedef enum logic [1:0] {
    LO      = 2'd0,
    PEND_HI = 2'd1,
    HI      = 2'd2,
    PEND_LO = 2'd3
  } deb_state_t;

  // Bit positions of each channel inside stuck_fault.
  localparam int unsigned A_IDX = 1;
  localparam int unsigned B_IDX = 0;

endpackage

// File: rtl/debounce_channel.sv
// One sensor channel: 2-flop synchronizer, debounce FSM, edge strobes, stuck-high detector.
// Latency: raw captured at edge k shows on clean_o at edge k+1+DEBOUNCE_CYCLES (for DEBOUNCE_CYCLES >= 2).
// Backpressure: none; strobes are single-cycle pulses that must be consumed when they occur.
module debounce_channel
  import gate_filter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned STUCK_CYCLES    = 500000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  input  logic fault_clr_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic stuck_o
);

  // Both counters share one width; STUCK_CYCLES is always the larger bound.
  localparam int unsigned CW = $clog2(STUCK_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] STUCK_MAX = CW'(STUCK_CYCLES);
  localparam logic [CW-1:0] STUCK_PRE = CW'(STUCK_CYCLES - 1);
  // A one-cycle debounce leaves PEND on its first cycle; entry already loads cnt=1.
  localparam bit DEB_ONE = (DEBOUNCE_CYCLES <= 1);

  logic          sync1_q;
  logic          sync2_q;
  deb_state_t    state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          clean_q,  clean_d;
  logic          rise_q,   rise_d;
  logic          fall_q,   fall_d;
  logic [CW-1:0] stk_cnt_q, stk_cnt_d;
  logic          stuck_q,  stuck_d;
  logic          s;
  logic          deb_done;

  assign s        = sync2_q;
  assign deb_done = DEB_ONE || (cnt_q == DEB_LAST);

  // Two-flop synchronizer bringing the asynchronous sensor into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM: a level change must persist DEBOUNCE_CYCLES cycles before clean flips.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LO: begin
        if (s) begin
          state_d = PEND_HI;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_d = LO;
          cnt_d   = CNT_ZERO;
        end else if (deb_done) begin
          state_d = HI;
          cnt_d   = CNT_ZERO;
          clean_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HI: begin
        if (!s) begin
          state_d = PEND_LO;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_LO: begin
        if (s) begin
          state_d = HI;
          cnt_d   = CNT_ZERO;
        end else if (deb_done) begin
          state_d = LO;
          cnt_d   = CNT_ZERO;
          clean_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // Stuck detector: saturating count of cycles with clean high; flag is sticky until cleared.
  always_comb begin
    stk_cnt_d = stk_cnt_q;
    stuck_d   = stuck_q;
    if (fault_clr_i) begin
      // Clear beats a coincident set and restarts the count.
      stk_cnt_d = CNT_ZERO;
      stuck_d   = 1'b0;
    end else if (!clean_q) begin
      stk_cnt_d = CNT_ZERO;
    end else if (stk_cnt_q != STUCK_MAX) begin
      stk_cnt_d = stk_cnt_q + CNT_ONE;
      if (stk_cnt_q == STUCK_PRE) begin
        stuck_d = 1'b1;
      end
    end
  end

  // State registers; reset throws away any debounce or stuck progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LO;
      cnt_q     <= CNT_ZERO;
      clean_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      stk_cnt_q <= CNT_ZERO;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      stk_cnt_q <= stk_cnt_d;
      stuck_q   <= stuck_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign stuck_o = stuck_q;

endmodule

// File: rtl/gate_sensor_filter.sv
// Conditions the outer (a) and inner (b) gate beams into clean levels, edge strobes and stuck flags.
// Latency: DEBOUNCE_CYCLES+2 cycles from raw capture to clean level and strobe.
// Backpressure: none; downstream must sample strobes every cycle.
module gate_sensor_filter
  import gate_filter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned STUCK_CYCLES    = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_raw,
  input  logic       b_raw,
  input  logic       fault_clr,
  output logic       a_clean,
  output logic       b_clean,
  output logic       a_rise,
  output logic       a_fall,
  output logic       b_rise,
  output logic       b_fall,
  output logic [1:0] stuck_fault
);

  logic a_stuck;
  logic b_stuck;

  // Outer beam channel.
  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_chan_a (
    .clk         (clk),
    .rst         (rst),
    .raw_i       (a_raw),
    .fault_clr_i (fault_clr),
    .clean_o     (a_clean),
    .rise_o      (a_rise),
    .fall_o      (a_fall),
    .stuck_o     (a_stuck)
  );

  // Inner beam channel.
  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_chan_b (
    .clk         (clk),
    .rst         (rst),
    .raw_i       (b_raw),
    .fault_clr_i (fault_clr),
    .clean_o     (b_clean),
    .rise_o      (b_rise),
    .fall_o      (b_fall),
    .stuck_o     (b_stuck)
  );

  // Pack per-channel stuck flags into the display-facing vector.
  always_comb begin
    stuck_fault        = 2'b00;
    stuck_fault[A_IDX] = a_stuck;
    stuck_fault[B_IDX] = b_stuck;
  end

endmodule

// File: tb/tb_gate_sensor_filter.sv
// Scoreboard bench for gate_sensor_filter with DEBOUNCE_CYCLES=4, STUCK_CYCLES=20.
// Stimulus pushes expected output events (strobe or stuck change) tagged with edge number.
// A negedge monitor pops and compares whenever the DUT shows a strobe or a stuck_fault change.
module tb_gate_sensor_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_raw;
  logic       b_raw;
  logic       fault_clr;
  logic       a_clean;
  logic       b_clean;
  logic       a_rise;
  logic       a_fall;
  logic       b_rise;
  logic       b_fall;
  logic [1:0] stuck_fault;

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  strb;   // {a_rise, a_fall, b_rise, b_fall}
    logic [1:0]  clean;  // {a_clean, b_clean}
    logic [1:0]  stuck;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  gate_sensor_filter #(
    .DEBOUNCE_CYCLES (4),
    .STUCK_CYCLES    (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .a_raw       (a_raw),
    .b_raw       (b_raw),
    .fault_clr   (fault_clr),
    .a_clean     (a_clean),
    .b_clean     (b_clean),
    .a_rise      (a_rise),
    .a_fall      (a_fall),
    .b_rise      (b_rise),
    .b_fall      (b_fall),
    .stuck_fault (stuck_fault)
  );

  initial forever #5 clk = ~clk;

  // Edge counter: at the negedge after edge N, cyc == N.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic expect_ev(input int unsigned c, input logic [3:0] s,
                           input logic [1:0] cl, input logic [1:0] st);
    ev_t e;
    e.cyc = c; e.strb = s; e.clean = cl; e.stuck = st;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b (cyc=%0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any strobe or stuck_fault change is an output event to score.
  initial begin
    logic [1:0] prev_stuck;
    logic [3:0] strb;
    ev_t        got;
    ev_t        e;
    prev_stuck = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stuck = stuck_fault;
      end else begin
        strb = {a_rise, a_fall, b_rise, b_fall};
        if (strb != 4'b0000 || stuck_fault != prev_stuck) begin
          got.cyc = cyc; got.strb = strb; got.clean = {a_clean, b_clean}; got.stuck = stuck_fault;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got cyc=%0d strb=%b clean=%b stuck=%b want none",
                     got.cyc, got.strb, got.clean, got.stuck);
          end else begin
            e = exp_q.pop_front();
            if (got != e)
              begin
                bad++;
                $display("FAIL event: got cyc=%0d strb=%b clean=%b stuck=%b want cyc=%0d strb=%b clean=%b stuck=%b",
                         got.cyc, got.strb, got.clean, got.stuck, e.cyc, e.strb, e.clean, e.stuck);
              end
          end
        end
        prev_stuck = stuck_fault;
      end
    end
  end

  initial begin
    int unsigned c;
    int unsigned r;
    ev_t         e;
    rst = 1'b1; a_raw = 1'b0; b_raw = 1'b0; fault_clr = 1'b0;
    step(3);
    chk("reset_state", {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, stuck_fault}, 8'h00);
    rst = 1'b0;
    step(3);

    // a held high: rise after 6, stuck 20 later, clear, stuck again, then fall.
    c = cyc;
    a_raw = 1'b1;
    expect_ev(c + 6,  4'b1000, 2'b10, 2'b00);
    expect_ev(c + 26, 4'b0000, 2'b10, 2'b10);
    step(10);
    chk("a_clean_high", {7'd0, a_clean}, 8'd1);
    chk("b_quiet", {5'd0, b_clean, b_rise, b_fall}, 8'd0);
    step(20);
    fault_clr = 1'b1;
    expect_ev(c + 31, 4'b0000, 2'b10, 2'b00);
    step(1);
    fault_clr = 1'b0;
    expect_ev(c + 51, 4'b0000, 2'b10, 2'b10);
    step(24);
    a_raw = 1'b0;
    expect_ev(c + 61, 4'b0100, 2'b00, 2'b10);
    step(12);

    // b glitch of 3 cycles is rejected.
    b_raw = 1'b1;
    step(3);
    b_raw = 1'b0;
    step(3);
    chk("glitch_mid", {7'd0, b_clean}, 8'd0);
    step(7);
    chk("glitch_end", {7'd0, b_clean}, 8'd0);

    // Entry pattern 10,11,01,00; b clean high exactly 20 cycles trips its stuck flag at the fall.
    c = cyc;
    a_raw = 1'b1; b_raw = 1'b0;
    expect_ev(c + 6,  4'b1000, 2'b10, 2'b10);
    expect_ev(c + 16, 4'b0010, 2'b11, 2'b10);
    expect_ev(c + 26, 4'b0100, 2'b01, 2'b10);
    expect_ev(c + 36, 4'b0001, 2'b00, 2'b11);
    step(10);
    b_raw = 1'b1;
    step(10);
    a_raw = 1'b0;
    step(10);
    b_raw = 1'b0;
    step(14);

    c = cyc;
    fault_clr = 1'b1;
    expect_ev(c + 1, 4'b0000, 2'b00, 2'b00);
    step(1);
    fault_clr = 1'b0;
    step(3);

    // Reset mid-debounce (a in PEND_HI cnt=3) with b_clean high: async clear, full requalify.
    c = cyc;
    b_raw = 1'b1;
    expect_ev(c + 6, 4'b0010, 2'b01, 2'b00);
    step(10);
    a_raw = 1'b1;
    step(5);
    chk("pre_reset_levels", {6'd0, a_clean, b_clean}, 8'd1);
    rst = 1'b1;
    b_raw = 1'b0;
    #1;
    chk("async_reset_outs", {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, stuck_fault}, 8'h00);
    step(3);
    rst = 1'b0;
    r = cyc;
    expect_ev(r + 6, 4'b1000, 2'b10, 2'b00);
    step(8);
    a_raw = 1'b0;
    expect_ev(r + 14, 4'b0100, 2'b00, 2'b00);
    step(12);

    // Simultaneous a/b edges.
    c = cyc;
    a_raw = 1'b1; b_raw = 1'b1;
    expect_ev(c + 6, 4'b1010, 2'b11, 2'b00);
    step(10);
    a_raw = 1'b0; b_raw = 1'b0;
    expect_ev(c + 16, 4'b0101, 2'b00, 2'b00);
    step(14);

    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event: got none want cyc=%0d strb=%b clean=%b stuck=%b",
               e.cyc, e.strb, e.clean, e.stuck);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
